// File: rtl/dcache_bus_port_pkg.sv
// -----------------------------------------------------------------------------
// dcache_bus_port_pkg
//   Shared types and constants for the data-cache bus port.
//   - word_t            : 32-bit bus word
//   - bus_port_state_t  : FSM state encoding of the bus port
//   - BLK_WORDS         : words per cache block (only 2 is supported)
//   - BLK_WORD1_OFS     : byte offset of the second word of a block
//   - BAD_DATA          : value driven on dstore when no write is in progress
//   - blk_align()       : force an address to block alignment
// -----------------------------------------------------------------------------
package dcache_bus_port_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        WB1   = 4'd1,
        WB2   = 4'd2,
        FILL1 = 4'd3,
        FILL2 = 4'd4,
        DONE  = 4'd5,
        SNOOP = 4'd6,
        SWB1  = 4'd7,
        SWB2  = 4'd8
    } bus_port_state_t;

    localparam int    BLK_WORDS     = 2;
    localparam word_t BLK_WORD1_OFS = 32'd4;
    localparam word_t BAD_DATA      = 32'hBAD0BAD0;

    // Blocks are two 32-bit words, so the low three address bits select
    // inside the block and are dropped.
    function automatic word_t blk_align(input word_t addr);
        return addr & ~32'h0000_0007;
    endfunction

endpackage

// File: rtl/dcache_bus_port_if.sv
// -----------------------------------------------------------------------------
// dcache_bus_port_if
//   Cache-control bus between one CPU's dcache bus port and memory_control.
//   master : the cache-side bus port (drives dREN/dWEN/daddr/dstore/cctrans/
//            ccwrite, receives dwait/dload and snoop requests)
//   slave  : memory_control side
// -----------------------------------------------------------------------------
interface dcache_bus_port_if;
    import dcache_bus_port_pkg::*;

    logic  dwait;
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dload;
    word_t dstore;
    logic  cctrans;
    logic  ccwrite;
    logic  ccwait;
    logic  ccinv;
    word_t ccsnoopaddr;

    modport master (
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
        output dREN, dWEN, daddr, dstore, cctrans, ccwrite
    );

    modport slave (
        output dwait, dload, ccwait, ccinv, ccsnoopaddr,
        input  dREN, dWEN, daddr, dstore, cctrans, ccwrite
    );

endinterface

// File: rtl/dcache_bus_port.sv
// -----------------------------------------------------------------------------
// dcache_bus_port
//   Cache-side end of the cache-control bus, one per CPU.
//   Initiator: a miss (req) becomes an optional two-word victim writeback
//   followed by a two-word coherent fill; done pulses once when the fill is
//   complete and fill_data0/1 hold the block from then on.
//   Responder: a snoop (ccwait) looks the block up in the cache (snp_hit,
//   snp_dirty), supplies dirty data on the bus and then invalidates
//   (snp_inv) or downgrades (snp_downgrade) the local copy.
//
//   Ports
//     CLK, nRST                    clock, asynchronous active-low reset
//     req, req_write, req_addr     miss request from the cache FSM
//     wb_valid, wb_addr, wb_data*  dirty victim to write back first
//     done, fill_data0/1           fill completion pulse and fill block
//     snp_hit/dirty/data*          cache lookup result for snp_addr
//     snp_addr                     block-aligned snooped address
//     snp_inv, snp_downgrade       pulses to update the local block state
//     snp_busy                     snoop in progress, cache holds its tags
//     bus                          cache-control bus (master side)
// -----------------------------------------------------------------------------
module dcache_bus_port
    import dcache_bus_port_pkg::*;
(
    input  logic                      CLK,
    input  logic                      nRST,

    input  logic                      req,
    input  logic                      req_write,
    input  word_t                     req_addr,
    input  logic                      wb_valid,
    input  word_t                     wb_addr,
    input  word_t                     wb_data0,
    input  word_t                     wb_data1,
    output logic                      done,
    output word_t                     fill_data0,
    output word_t                     fill_data1,

    input  logic                      snp_hit,
    input  logic                      snp_dirty,
    input  word_t                     snp_data0,
    input  word_t                     snp_data1,
    output word_t                     snp_addr,
    output logic                      snp_inv,
    output logic                      snp_downgrade,
    output logic                      snp_busy,

    dcache_bus_port_if.master         bus
);

    bus_port_state_t state_q, state_d;
    word_t           fill_data0_q, fill_data0_d;
    word_t           fill_data1_q, fill_data1_d;

    word_t           req_base;
    word_t           wb_base;

    // Misaligned addresses are masked; the second word is always base+4
    // with no carry out of the in-block offset.
    assign req_base = blk_align(req_addr);
    assign wb_base  = blk_align(wb_addr);
    assign snp_addr = blk_align(bus.ccsnoopaddr);

    assign fill_data0 = fill_data0_q;
    assign fill_data1 = fill_data1_q;

    // State register and fill buffer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            fill_data0_q <= '0;
            fill_data1_q <= '0;
        end else begin
            state_q      <= state_d;
            fill_data0_q <= fill_data0_d;
            fill_data1_q <= fill_data1_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A pending snoop wins over our own miss.
                if (bus.ccwait)      state_d = SNOOP;
                else if (req)        state_d = wb_valid ? WB1 : FILL1;
            end
            WB1:   if (!bus.dwait) state_d = WB2;
            WB2:   if (!bus.dwait) state_d = FILL1;
            FILL1: if (!bus.dwait) state_d = FILL2;
            FILL2: if (!bus.dwait) state_d = DONE;
            DONE:  state_d = IDLE;
            SNOOP: state_d = (snp_hit && snp_dirty) ? SWB1 : IDLE;
            SWB1:  if (!bus.dwait) state_d = SWB2;
            SWB2:  if (!bus.dwait) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fill capture: a read word is taken in the cycle memory stops waiting.
    always_comb begin
        fill_data0_d = fill_data0_q;
        fill_data1_d = fill_data1_q;
        if (!bus.dwait) begin
            if (state_q == FILL1) fill_data0_d = bus.dload;
            if (state_q == FILL2) fill_data1_d = bus.dload;
        end
    end

    // Output decode
    always_comb begin
        done          = 1'b0;
        snp_inv       = 1'b0;
        snp_downgrade = 1'b0;
        snp_busy      = 1'b0;
        bus.dREN      = 1'b0;
        bus.dWEN      = 1'b0;
        bus.daddr     = '0;
        bus.dstore    = BAD_DATA;
        bus.cctrans   = 1'b0;
        bus.ccwrite   = 1'b0;

        case (state_q)
            WB1: begin
                bus.dWEN    = 1'b1;
                bus.cctrans = 1'b1;
                bus.daddr   = wb_base;
                bus.dstore  = wb_data0;
            end
            WB2: begin
                bus.dWEN    = 1'b1;
                bus.cctrans = 1'b1;
                bus.daddr   = wb_base + BLK_WORD1_OFS;
                bus.dstore  = wb_data1;
            end
            FILL1: begin
                bus.dREN    = 1'b1;
                bus.cctrans = 1'b1;
                bus.ccwrite = req_write;
                bus.daddr   = req_base;
            end
            FILL2: begin
                bus.dREN    = 1'b1;
                bus.cctrans = 1'b1;
                bus.ccwrite = req_write;
                bus.daddr   = req_base + BLK_WORD1_OFS;
            end
            DONE: begin
                done = 1'b1;
            end
            SNOOP: begin
                snp_busy = 1'b1;
                // ccwrite tells memory_control that this cache supplies data.
                if (snp_hit && snp_dirty)      bus.ccwrite = 1'b1;
                else if (snp_hit && bus.ccinv) snp_inv     = 1'b1;
            end
            SWB1: begin
                snp_busy    = 1'b1;
                bus.dWEN    = 1'b1;
                bus.ccwrite = 1'b1;
                bus.daddr   = snp_addr;
                bus.dstore  = snp_data0;
            end
            SWB2: begin
                snp_busy    = 1'b1;
                bus.dWEN    = 1'b1;
                bus.ccwrite = 1'b1;
                bus.daddr   = snp_addr + BLK_WORD1_OFS;
                bus.dstore  = snp_data1;
                // The local block changes state only once its data is out.
                if (!bus.dwait) begin
                    if (bus.ccinv) snp_inv       = 1'b1;
                    else           snp_downgrade = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
